// File: rtl/tile_load_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : tile_load_sched_if
//  Description : Command, CPU-arbitration and SRAM read-side bundle of the
//                tile load scheduler.
//                master : the scheduler (drives strobes, tags, status)
//                slave  : the surrounding system (drives start/K_len/cpu_*_we)
//  Ports       : start, K_len            command
//                busy, done, err_klen    status
//                cpu_w_we, cpu_x_we      CPU preload writes (win arbitration)
//                w_rd_en/row/k           W SRAM read request
//                x_rd_en/k/n             X SRAM read request
//                w_rvalid/w_row_q/w_k_q  tagged W beat (1 cycle after request)
//                x_rvalid/x_k_q/x_n_q    tagged X beat (1 cycle after request)
//                stall_cnt               reads lost to CPU writes
//  Revision    : 1.0  initial release
// ============================================================================
interface tile_load_sched_if #(
    parameter int M    = 8,
    parameter int N    = 8,
    parameter int KMAX = 1024
);
    localparam int K_W   = (KMAX > 1) ? $clog2(KMAX) : 1;
    localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam int N_W   = (N > 1) ? $clog2(N) : 1;

    logic             start;
    logic [15:0]      K_len;
    logic             busy;
    logic             done;
    logic             err_klen;
    logic             cpu_w_we;
    logic             cpu_x_we;
    logic             w_rd_en;
    logic [ROW_W-1:0] w_rd_row;
    logic [K_W-1:0]   w_rd_k;
    logic             x_rd_en;
    logic [K_W-1:0]   x_rd_k;
    logic [N_W-1:0]   x_rd_n;
    logic             w_rvalid;
    logic [ROW_W-1:0] w_row_q;
    logic [K_W-1:0]   w_k_q;
    logic             x_rvalid;
    logic [K_W-1:0]   x_k_q;
    logic [N_W-1:0]   x_n_q;
    logic [31:0]      stall_cnt;

    modport master (
        input  start, K_len, cpu_w_we, cpu_x_we,
        output busy, done, err_klen,
        output w_rd_en, w_rd_row, w_rd_k, x_rd_en, x_rd_k, x_rd_n,
        output w_rvalid, w_row_q, w_k_q, x_rvalid, x_k_q, x_n_q,
        output stall_cnt
    );

    modport slave (
        output start, K_len, cpu_w_we, cpu_x_we,
        input  busy, done, err_klen,
        input  w_rd_en, w_rd_row, w_rd_k, x_rd_en, x_rd_k, x_rd_n,
        input  w_rvalid, w_row_q, w_k_q, x_rvalid, x_k_q, x_n_q,
        input  stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/tile_load_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tile_load_sched
//  Description : Walks k = 0..K_len-1 and, for each k, issues M one-beat reads
//                to the W SRAM (rows) and N to the X SRAM (columns), one beat
//                per cycle per stream. CPU preload writes always win the
//                single SRAM port; a blocked read is retried the next cycle.
//                Read data is tagged one cycle after the strobe.
//  Ports       : clk, rst_n (synchronous, active low), bus (tile_load_sched_if
//                master modport: command, status, SRAM read strobes, tags,
//                stall counter)
//  Options     : TILE_SCHED_PERF_EN - enables the saturating stall_cnt;
//                when undefined stall_cnt is tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module tile_load_sched #(
    parameter int M    = 8,
    parameter int N    = 8,
    parameter int KMAX = 1024
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    tile_load_sched_if.master  bus
);
    localparam int K_W   = (KMAX > 1) ? $clog2(KMAX) : 1;
    localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam int N_W   = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // Per-stream counters carry one extra bit so "all beats issued" (== M/N)
    // is a distinct value from the last row/column index.
    localparam logic [ROW_W:0] c_M      = (ROW_W+1)'(M);
    localparam logic [ROW_W:0] c_M_LAST = (ROW_W+1)'(M - 1);
    localparam logic [N_W:0]   c_N      = (N_W+1)'(N);
    localparam logic [N_W:0]   c_N_LAST = (N_W+1)'(N - 1);
    localparam logic [15:0]    c_KMAX   = 16'(KMAX);

    logic [1:0]       r_state;
    logic [ROW_W:0]   r_row;
    logic [N_W:0]     r_n;
    logic [K_W:0]     r_k;      // one bit wider so K_len == KMAX ends cleanly
    logic [K_W:0]     r_klen;
    logic             r_err;
    logic [ROW_W-1:0] r_w_row_hold;
    logic [K_W-1:0]   r_w_k_hold;
    logic [K_W-1:0]   r_x_k_hold;
    logic [N_W-1:0]   r_x_n_hold;
    logic             r_w_rvalid;
    logic [ROW_W-1:0] r_w_row_q;
    logic [K_W-1:0]   r_w_k_q;
    logic             r_x_rvalid;
    logic [K_W-1:0]   r_x_k_q;
    logic [N_W-1:0]   r_x_n_q;

    logic             w_load;
    logic             w_w_pend;
    logic             w_x_pend;
    logic             w_w_issue;
    logic             w_x_issue;
    logic             w_w_fin;
    logic             w_x_fin;
    logic             w_k_adv;
    logic [K_W:0]     w_k_next;
    logic             w_start_ok;
    logic             w_klen_ok;
    logic [ROW_W-1:0] w_w_row_sel;
    logic [K_W-1:0]   w_w_k_sel;
    logic [K_W-1:0]   w_x_k_sel;
    logic [N_W-1:0]   w_x_n_sel;

    assign w_load     = (r_state == c_ST_LOAD);
    assign w_w_pend   = (r_row != c_M);
    assign w_x_pend   = (r_n != c_N);
    assign w_w_issue  = w_load && w_w_pend && !bus.cpu_w_we;
    assign w_x_issue  = w_load && w_x_pend && !bus.cpu_x_we;
    // A stream counts as finished for this k if it already was, or its last
    // beat goes out this cycle; k advances once both are finished.
    assign w_w_fin    = !w_w_pend || (w_w_issue && (r_row == c_M_LAST));
    assign w_x_fin    = !w_x_pend || (w_x_issue && (r_n == c_N_LAST));
    assign w_k_adv    = w_load && w_w_fin && w_x_fin;
    assign w_k_next   = r_k + 1'b1;
    assign w_start_ok = (r_state == c_ST_IDLE) && bus.start;
    assign w_klen_ok  = (bus.K_len != 16'd0) && (bus.K_len <= c_KMAX);

    // Addresses follow the counters while issuing, otherwise hold the last
    // address actually presented to the SRAM.
    assign w_w_row_sel = w_w_issue ? r_row[ROW_W-1:0] : r_w_row_hold;
    assign w_w_k_sel   = w_w_issue ? r_k[K_W-1:0]     : r_w_k_hold;
    assign w_x_k_sel   = w_x_issue ? r_k[K_W-1:0]     : r_x_k_hold;
    assign w_x_n_sel   = w_x_issue ? r_n[N_W-1:0]     : r_x_n_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_row        <= '0;
            r_n          <= '0;
            r_k          <= '0;
            r_klen       <= '0;
            r_err        <= 1'b0;
            r_w_row_hold <= '0;
            r_w_k_hold   <= '0;
            r_x_k_hold   <= '0;
            r_x_n_hold   <= '0;
            r_w_rvalid   <= 1'b0;
            r_w_row_q    <= '0;
            r_w_k_q      <= '0;
            r_x_rvalid   <= 1'b0;
            r_x_k_q      <= '0;
            r_x_n_q      <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_err  <= (bus.K_len > c_KMAX);
                        r_klen <= bus.K_len[K_W:0];
                        r_row  <= '0;
                        r_n    <= '0;
                        r_k    <= '0;
                        // Rejected lengths still pass through DRAIN so the
                        // completion pulse has the same two-cycle latency.
                        r_state <= w_klen_ok ? c_ST_LOAD : c_ST_DRAIN;
                    end
                end
                c_ST_LOAD: begin
                    if (w_k_adv) begin
                        r_row <= '0;
                        r_n   <= '0;
                        r_k   <= w_k_next;
                        if (w_k_next == r_klen) begin
                            r_state <= c_ST_DRAIN;
                        end
                    end else begin
                        if (w_w_issue) r_row <= r_row + 1'b1;
                        if (w_x_issue) r_n   <= r_n + 1'b1;
                    end
                end
                c_ST_DRAIN: r_state <= c_ST_DONE;
                c_ST_DONE:  r_state <= c_ST_IDLE;
                default:    r_state <= c_ST_IDLE;
            endcase

            r_w_row_hold <= w_w_row_sel;
            r_w_k_hold   <= w_w_k_sel;
            r_x_k_hold   <= w_x_k_sel;
            r_x_n_hold   <= w_x_n_sel;

            r_w_rvalid   <= w_w_issue;
            r_w_row_q    <= w_w_row_sel;
            r_w_k_q      <= w_w_k_sel;
            r_x_rvalid   <= w_x_issue;
            r_x_k_q      <= w_x_k_sel;
            r_x_n_q      <= w_x_n_sel;
        end
    end

    assign bus.busy     = (r_state != c_ST_IDLE);
    assign bus.done     = (r_state == c_ST_DONE);
    assign bus.err_klen = r_err;
    assign bus.w_rd_en  = w_w_issue;
    assign bus.w_rd_row = w_w_row_sel;
    assign bus.w_rd_k   = w_w_k_sel;
    assign bus.x_rd_en  = w_x_issue;
    assign bus.x_rd_k   = w_x_k_sel;
    assign bus.x_rd_n   = w_x_n_sel;
    assign bus.w_rvalid = r_w_rvalid;
    assign bus.w_row_q  = r_w_row_q;
    assign bus.w_k_q    = r_w_k_q;
    assign bus.x_rvalid = r_x_rvalid;
    assign bus.x_k_q    = r_x_k_q;
    assign bus.x_n_q    = r_x_n_q;

`ifdef TILE_SCHED_PERF_EN
    logic [31:0] r_stall;
    logic [1:0]  w_stall_inc;
    logic [32:0] w_stall_sum;

    // A stream is stalled when it still owes beats for this k but its SRAM
    // port is taken by a CPU write.
    assign w_stall_inc = {1'b0, (w_load && w_w_pend && bus.cpu_w_we)}
                       + {1'b0, (w_load && w_x_pend && bus.cpu_x_we)};
    assign w_stall_sum = {1'b0, r_stall} + {31'd0, w_stall_inc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (w_start_ok) begin
            r_stall <= '0;
        end else if (w_load) begin
            r_stall <= w_stall_sum[32] ? 32'hFFFF_FFFF : w_stall_sum[31:0];
        end
    end

    assign bus.stall_cnt = r_stall;
`else
    assign bus.stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tile_load_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_load_sched
//  Description : Self-checking bench for tile_load_sched. A behavioural model
//                tracks the command phase, per-k beat budgets and the expected
//                beat order; the DUT is compared against it every cycle, and
//                directed scenarios pin completion latency and beat counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tile_load_sched;
    localparam int M     = 8;
    localparam int N     = 8;
    localparam int KMAX  = 1024;
    localparam int K_W   = 10;
    localparam int ROW_W = 3;
    localparam int N_W   = 3;

    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_DONE  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    int   w_beats = 0;
    int   x_beats = 0;

    tile_load_sched_if #(.M(M), .N(N), .KMAX(KMAX)) bus ();

    tile_load_sched #(.M(M), .N(N), .KMAX(KMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tot = n_tot + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    int     m_ph = PH_IDLE;
    int     m_klen = 0;
    int     m_k = 0;
    int     m_wc = 0;
    int     m_xc = 0;
    bit     m_err = 1'b0;
    longint m_stall = 0;
    bit     m_pw = 1'b0;
    bit     m_px = 1'b0;
    int     m_pw_row = 0, m_pw_k = 0, m_px_k = 0, m_px_n = 0;
    int     m_lw_row = 0, m_lw_k = 0, m_lx_k = 0, m_lx_n = 0;
    int     qw[$];
    int     qx[$];
    bit     e_wen, e_xen;
    int     tag;
`ifdef TILE_SCHED_PERF_EN
    int     blk;
`endif

    initial forever begin
        @(negedge clk);
        if (cyc >= 1) begin
            e_wen = (m_ph == PH_LOAD) && (m_wc < M) && !bus.cpu_w_we;
            e_xen = (m_ph == PH_LOAD) && (m_xc < N) && !bus.cpu_x_we;
            if (e_wen) begin m_lw_row = m_wc; m_lw_k = m_k; end
            if (e_xen) begin m_lx_k = m_k; m_lx_n = m_xc; end

            chk("ctl_busy_done_err", {bus.busy, bus.done, bus.err_klen},
                {m_ph != PH_IDLE, m_ph == PH_DONE, m_err});
            chk("w_rd_en_row_k", {bus.w_rd_en, bus.w_rd_row, bus.w_rd_k},
                {e_wen, ROW_W'(m_lw_row), K_W'(m_lw_k)});
            chk("x_rd_en_k_n", {bus.x_rd_en, bus.x_rd_k, bus.x_rd_n},
                {e_xen, K_W'(m_lx_k), N_W'(m_lx_n)});
            chk("w_rvalid", bus.w_rvalid, m_pw);
            chk("x_rvalid", bus.x_rvalid, m_px);
            if (m_pw) chk("w_tag", {bus.w_k_q, bus.w_row_q}, {K_W'(m_pw_k), ROW_W'(m_pw_row)});
            if (m_px) chk("x_tag", {bus.x_k_q, bus.x_n_q}, {K_W'(m_px_k), N_W'(m_px_n)});
            chk("stall_cnt", bus.stall_cnt, m_stall);

            if (bus.w_rvalid) begin
                w_beats = w_beats + 1;
                if (qw.size() == 0) chk("w_extra_beat", 1, 0);
                else begin
                    tag = qw.pop_front();
                    chk("w_order", int'(bus.w_k_q) * 256 + int'(bus.w_row_q), tag);
                end
            end
            if (bus.x_rvalid) begin
                x_beats = x_beats + 1;
                if (qx.size() == 0) chk("x_extra_beat", 1, 0);
                else begin
                    tag = qx.pop_front();
                    chk("x_order", int'(bus.x_k_q) * 256 + int'(bus.x_n_q), tag);
                end
            end

            // advance to the next cycle
            if (!rst_n) begin
                m_ph = PH_IDLE; m_k = 0; m_wc = 0; m_xc = 0; m_klen = 0;
                m_err = 1'b0; m_stall = 0; m_pw = 1'b0; m_px = 1'b0;
                m_lw_row = 0; m_lw_k = 0; m_lx_k = 0; m_lx_n = 0;
                qw.delete(); qx.delete();
            end else begin
                m_pw = e_wen; m_px = e_xen;
                m_pw_row = m_lw_row; m_pw_k = m_lw_k;
                m_px_k = m_lx_k; m_px_n = m_lx_n;
                case (m_ph)
                    PH_IDLE: begin
                        if (bus.start) begin
                            m_klen = int'(bus.K_len);
                            m_err = (m_klen > KMAX);
                            m_stall = 0; m_k = 0; m_wc = 0; m_xc = 0;
                            qw.delete(); qx.delete();
                            if (m_klen > 0 && m_klen <= KMAX) begin
                                m_ph = PH_LOAD;
                                for (int k = 0; k < m_klen; k++)
                                    for (int i = 0; i < M; i++) begin
                                        qw.push_back(k * 256 + i);
                                        qx.push_back(k * 256 + i);
                                    end
                            end else begin
                                m_ph = PH_DRAIN;
                            end
                        end
                    end
                    PH_LOAD: begin
`ifdef TILE_SCHED_PERF_EN
                        blk = 0;
                        if (m_wc < M && bus.cpu_w_we) blk = blk + 1;
                        if (m_xc < N && bus.cpu_x_we) blk = blk + 1;
                        m_stall = m_stall + blk;
                        if (m_stall > 64'hFFFF_FFFF) m_stall = 64'hFFFF_FFFF;
`endif
                        if (e_wen) m_wc = m_wc + 1;
                        if (e_xen) m_xc = m_xc + 1;
                        if (m_wc == M && m_xc == N) begin
                            m_wc = 0; m_xc = 0; m_k = m_k + 1;
                            if (m_k == m_klen) m_ph = PH_DRAIN;
                        end
                    end
                    PH_DRAIN: m_ph = PH_DONE;
                    default:  m_ph = PH_IDLE;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    // Issues start in cycle 0 and returns the cycle (relative to the start
    // edge) in which done was seen, or -1.
    task automatic run_op(input int klen, input int wlo, input int whi,
                          input int re_at, input int re_k, input int rst_at,
                          input bit rnd, output int done_at);
        int lim;
        lim = (rst_at > 0) ? rst_at + 40 : 20000;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.K_len = 16'(klen);
        bus.cpu_w_we = 1'b0; bus.cpu_x_we = 1'b0;
        w_beats = 0; x_beats = 0; done_at = -1;
        for (int t = 1; t <= lim; t++) begin
            @(posedge clk); #1;
            if (t == rst_at + 1)
                chk("rst_outputs_zero",
                    {bus.busy, bus.done, bus.err_klen, bus.w_rd_en, bus.x_rd_en,
                     bus.w_rvalid, bus.x_rvalid, bus.stall_cnt}, 0);
            if (bus.done) begin done_at = t; break; end
            bus.start = (t == re_at);
            if (t == re_at) bus.K_len = 16'(re_k);
            rst_n = (t != rst_at);
            if (rnd) begin
                bus.cpu_w_we = ($urandom_range(3) == 0);
                bus.cpu_x_we = ($urandom_range(3) == 0);
            end else begin
                bus.cpu_w_we = (t >= wlo && t <= whi);
                bus.cpu_x_we = 1'b0;
            end
        end
        bus.start = 1'b0; bus.cpu_w_we = 1'b0; bus.cpu_x_we = 1'b0; rst_n = 1'b1;
        if (done_at < 0 && rst_at <= 0) chk("done_timeout", 0, 1);
    endtask

    int d;
    int rk;
    int rr;

    initial begin
        bus.start = 1'b0; bus.K_len = 16'd0;
        bus.cpu_w_we = 1'b0; bus.cpu_x_we = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("reset_outputs",
            {bus.busy, bus.done, bus.err_klen, bus.w_rd_en, bus.x_rd_en,
             bus.w_rvalid, bus.x_rvalid}, 0);
        chk("reset_stall", bus.stall_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // K_len = 10, no CPU traffic
        run_op(10, -1, -1, -1, 0, -1, 1'b0, d);
        chk("t1_done_cycle", d, 82);
        chk("t1_w_beats", w_beats, 80);
        chk("t1_x_beats", x_beats, 80);
        chk("t1_err", bus.err_klen, 0);

        // K_len = 3, CPU holds W port in cycles 2..5
        run_op(3, 2, 5, -1, 0, -1, 1'b0, d);
        chk("t2_done_cycle", d, 30);
        chk("t2_w_beats", w_beats, 24);
        chk("t2_x_beats", x_beats, 24);
`ifdef TILE_SCHED_PERF_EN
        chk("t2_stall_cnt", bus.stall_cnt, 4);
`else
        chk("t2_stall_cnt", bus.stall_cnt, 0);
`endif

        // zero and over-long lengths
        run_op(0, -1, -1, -1, 0, -1, 1'b0, d);
        chk("t3_k0_done_cycle", d, 2);
        chk("t3_k0_err", bus.err_klen, 0);
        chk("t3_k0_beats", w_beats + x_beats, 0);
        run_op(1025, -1, -1, -1, 0, -1, 1'b0, d);
        chk("t3_kbig_done_cycle", d, 2);
        chk("t3_kbig_err", bus.err_klen, 1);
        chk("t3_kbig_beats", w_beats + x_beats, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_err_sticky", bus.err_klen, 1);
        run_op(1, -1, -1, -1, 0, -1, 1'b0, d);
        chk("t3_err_cleared", bus.err_klen, 0);
        chk("t3_k1_done_cycle", d, 10);

        // second start during LOAD must be ignored
        run_op(5, -1, -1, 10, 2, -1, 1'b0, d);
        chk("t4_done_cycle", d, 42);
        chk("t4_w_beats", w_beats, 40);
        chk("t4_x_beats", x_beats, 40);

        // reset mid-operation, then a normal short run
        run_op(10, -1, -1, -1, 0, 20, 1'b0, d);
        chk("t5_no_done", d, -1);
        run_op(1, -1, -1, -1, 0, -1, 1'b0, d);
        chk("t5_k1_done_cycle", d, 10);
        chk("t5_k1_w_beats", w_beats, 8);
        chk("t5_k1_x_beats", x_beats, 8);

        // maximum depth terminates without wrapping
        run_op(KMAX, -1, -1, -1, 0, -1, 1'b0, d);
        chk("t6_kmax_done_cycle", d, 8 * KMAX + 2);
        chk("t6_kmax_w_beats", w_beats, 8 * KMAX);

        // randomized CPU traffic, lengths and stray starts
        for (int i = 0; i < 12; i++) begin
            rr = int'($urandom_range(9));
            rk = (rr == 9) ? 1025 : rr;
            run_op(rk, -1, -1, int'($urandom_range(1, 20)), int'($urandom_range(1, 4)),
                   -1, 1'b1, d);
            chk("rnd_done_seen", d > 0, 1);
            if (rk >= 1 && rk <= KMAX) begin
                chk("rnd_w_beats", w_beats, 8 * rk);
                chk("rnd_x_beats", x_beats, 8 * rk);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
`default_nettype wire
